// File: rtl/code_converter_pkg.sv
// rtl/code_converter_pkg.sv - constants, mode enum and Gray helpers for code_converter
package code_converter_pkg;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    function automatic logic [3:0] bin2gray(input logic [3:0] n);
        return {n[3], n[3] ^ n[2], n[2] ^ n[1], n[1] ^ n[0]};
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

endpackage

// File: rtl/code_converter_core.sv
// rtl/code_converter_core.sv - combinational BCD/XS3 and bin/Gray mapping
// Range checking on channel 1 is enabled by CODE_CONVERTER_ERR_EN.
module code_converter_core
    import code_converter_pkg::*;
(
    input  logic [3:0] i_n,
    input  mode_e      i_mode,
    output logic [3:0] o_ch1,
    output logic [3:0] o_ch2,
    output logic       o_err
);

`ifdef CODE_CONVERTER_ERR_EN
    logic w_out_of_range;

    always_comb begin
        w_out_of_range = 1'b0;
        if (i_mode == MODE_ENC) begin
            w_out_of_range = (i_n > BCD_MAX);
        end else begin
            w_out_of_range = (i_n < XS3_MIN) || (i_n > XS3_MAX);
        end
    end
`endif

    always_comb begin
        o_ch1 = 4'd0;
        o_ch2 = 4'd0;
        o_err = 1'b0;
        if (i_mode == MODE_ENC) begin
            o_ch1 = i_n + XS3_OFFSET;
            o_ch2 = bin2gray(i_n);
        end else begin
            o_ch1 = i_n - XS3_OFFSET;
            o_ch2 = gray2bin(i_n);
        end
`ifdef CODE_CONVERTER_ERR_EN
        // Illegal channel-1 codes are squashed so downstream never sees garbage.
        if (w_out_of_range) begin
            o_ch1 = 4'd0;
            o_err = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/code_converter.sv
// rtl/code_converter.sv - registered dual-channel nibble code converter (top)
// Optional channel-1 range check: define CODE_CONVERTER_ERR_EN.
module code_converter
    import code_converter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic mode,
    input  logic in_valid,
    output logic a1,
    output logic b1,
    output logic c1,
    output logic d1,
    output logic a2,
    output logic b2,
    output logic c2,
    output logic d2,
    output logic out_valid,
    output logic err
);

    logic [3:0] w_n;
    mode_e      w_mode;
    logic [3:0] w_ch1;
    logic [3:0] w_ch2;
    logic       w_err;

    logic [3:0] r_ch1;
    logic [3:0] r_ch2;
    logic       r_err;
    logic       r_valid;

    assign w_n    = {a, b, c, d};
    assign w_mode = mode_e'(mode);

    code_converter_core u_core (
        .i_n    (w_n),
        .i_mode (w_mode),
        .o_ch1  (w_ch1),
        .o_ch2  (w_ch2),
        .o_err  (w_err)
    );

    // Results hold across idle cycles; only out_valid tracks in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch1   <= 4'd0;
            r_ch2   <= 4'd0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_ch1 <= w_ch1;
                r_ch2 <= w_ch2;
                r_err <= w_err;
            end
        end
    end

    assign {a1, b1, c1, d1} = r_ch1;
    assign {a2, b2, c2, d2} = r_ch2;
    assign err              = r_err;
    assign out_valid        = r_valid;

endmodule

// File: tb/tb_code_converter.sv
// tb/tb_code_converter.sv - scoreboard bench for code_converter
module tb_code_converter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic mode = 1'b0;
    logic in_valid = 1'b0;
    logic a1, b1, c1, d1, a2, b2, c2, d2, out_valid, err;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] last_exp = 9'd0;

    logic [3:0] enc1_tbl [16] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                                  4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    logic [3:0] dec1_tbl [16] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                  4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    logic [3:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    logic [3:0] bin_tbl  [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                                  4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};

    code_converter dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .mode      (mode),
        .in_valid  (in_valid),
        .a1        (a1),
        .b1        (b1),
        .c1        (c1),
        .d1        (d1),
        .a2        (a2),
        .b2        (b2),
        .c2        (c2),
        .d2        (d2),
        .out_valid (out_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] model(input logic [3:0] n, input logic m);
        logic [3:0] ch1;
        logic [3:0] ch2;
        logic       e;
        ch1 = m ? dec1_tbl[n] : enc1_tbl[n];
        ch2 = m ? bin_tbl[n]  : gray_tbl[n];
        e   = 1'b0;
`ifdef CODE_CONVERTER_ERR_EN
        if (m ? (n < 4'd3 || n > 4'd12) : (n > 4'd9)) begin
            ch1 = 4'd0;
            e   = 1'b1;
        end
`endif
        return {ch1, ch2, e};
    endfunction

    function automatic logic [8:0] outs();
        return {a1, b1, c1, d1, a2, b2, c2, d2, err};
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] n, input logic m);
        {a, b, c, d} = n;
        mode     = m;
        in_valid = 1'b1;
        exp_q.push_back(model(n, m));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented result is popped against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {1'b1, outs()}, 10'd0);
            end else begin
                last_exp = exp_q.pop_front();
                chk("result", {out_valid, outs()}, {1'b1, last_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        {a, b, c, d} = 4'b1111;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", {out_valid, outs()}, 10'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(4'd15, 1'b0);

        for (int n = 0; n <= 9; n++) drive(4'(n), 1'b0);
        for (int n = 0; n <= 15; n++) drive(4'(n), 1'b1);
        drive(4'd10, 1'b0);
        drive(4'd1, 1'b1);

        drive(4'd6, 1'b0);
        in_valid     = 1'b0;
        {a, b, c, d} = 4'd9;
        mode         = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("gap_hold", {out_valid, outs()}, {1'b0, last_exp});
        end
        drive(4'd7, 1'b0);

        for (int n = 0; n <= 9; n++) begin
            drive(4'(n), 1'b0);
            drive(enc1_tbl[n], 1'b1);
        end
        for (int n = 0; n <= 15; n++) begin
            drive(4'(n), 1'b0);
            drive(gray_tbl[n], 1'b1);
        end

        drive(4'd13, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset", {out_valid, outs()}, 10'd0);
        @(posedge clk);
        #1;
        chk("reset_held", {out_valid, outs()}, 10'd0);
        rst = 1'b0;
        drive(4'd12, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("queue_drained", 10'(exp_q.size()), 10'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
